// File: rtl/col2im_pkg.sv
// col2im_pkg: shared FSM state type, default geometry and width helpers.
// Imported by the col2im top and its address generator.
package col2im_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_C  = 1;
  localparam int DEF_W  = 8;
  localparam int DEF_H  = 8;
  localparam int DEF_K  = 3;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 32;

  // counter width able to hold 0..n-1, at least one bit
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // sum of K*K unsigned words never overflows this width
  function automatic int acc_w(input int dw, input int k);
    return dw + $clog2(k * k + 1);
  endfunction

endpackage

// File: rtl/col2im_if.sv
// col2im_if: memory-side bus of col2im (column read port, image write port).
// master: addr_rd, addr_wr, data_wr, mem_wr_en out, data_rd in; slave mirrors.
interface col2im_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  mem_wr_en;

  modport master (
    output addr_rd, addr_wr, data_wr, mem_wr_en,
    input  data_rd
  );

  modport slave (
    input  addr_rd, addr_wr, data_wr, mem_wr_en,
    output data_rd
  );
endinterface

// File: rtl/col2im_addr_gen.sv
// col2im_addr_gen: walks r,c,ch,fr,fc (fc innermost) over the column matrix.
// Ports: clk, rst_n, clear, step in; addr, ty/tx/tch target, inb, last out.
module col2im_addr_gen
  import col2im_pkg::*;
#(
  parameter int IMG_C       = DEF_C,
  parameter int IMG_W       = DEF_W,
  parameter int IMG_H       = DEF_H,
  parameter int FILTER_SIZE = DEF_K,
  parameter int ADDR_WIDTH  = DEF_AW,
  parameter logic [ADDR_WIDTH-1:0] COL_BASE = 'h2000,
  localparam int RW  = cw(IMG_H),
  localparam int CXW = cw(IMG_W),
  localparam int CHW = cw(IMG_C),
  localparam int FW  = cw(FILTER_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [RW-1:0]         ty,
  output logic [CXW-1:0]        tx,
  output logic [CHW-1:0]        tch,
  output logic                  inb,
  output logic                  last
);
  localparam int P = (FILTER_SIZE - 1) / 2;

  logic [RW-1:0]  r;
  logic [CXW-1:0] c;
  logic [CHW-1:0] ch;
  logic [FW-1:0]  fr;
  logic [FW-1:0]  fc;
  logic fc_end, fr_end, ch_end, c_end, r_end;
  int   y_i, x_i;

  assign fc_end = (fc == FW'(FILTER_SIZE - 1));
  assign fr_end = (fr == FW'(FILTER_SIZE - 1));
  assign ch_end = (ch == CHW'(IMG_C - 1));
  assign c_end  = (c == CXW'(IMG_W - 1));
  assign r_end  = (r == RW'(IMG_H - 1));
  assign last   = fc_end & fr_end & ch_end & c_end & r_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r    <= '0;
      c    <= '0;
      ch   <= '0;
      fr   <= '0;
      fc   <= '0;
      addr <= COL_BASE;
    end else if (step) begin
      addr <= addr + 1'b1;
      fc   <= fc_end ? '0 : fc + 1'b1;
      if (fc_end)
        fr <= fr_end ? '0 : fr + 1'b1;
      if (fc_end && fr_end)
        ch <= ch_end ? '0 : ch + 1'b1;
      if (fc_end && fr_end && ch_end)
        c <= c_end ? '0 : c + 1'b1;
      if (fc_end && fr_end && ch_end && c_end)
        r <= r_end ? '0 : r + 1'b1;
    end
  end

  // signed target so padding taps land below zero
  always_comb begin
    y_i = int'(r) + int'(fr) - P;
    x_i = int'(c) + int'(fc) - P;
  end

  assign inb = (y_i >= 0) && (y_i < IMG_H) &&
               (x_i >= 0) && (x_i < IMG_W);
  assign ty  = y_i[RW-1:0];
  assign tx  = x_i[CXW-1:0];
  assign tch = ch;

endmodule

// File: rtl/col2im.sv
// col2im: reads an im2col column matrix, scatter-adds taps per pixel,
// writes the saturated image. Ports: clk, rst_n, start, done, mem bus.
module col2im
  import col2im_pkg::*;
#(
  parameter int IMG_C       = DEF_C,
  parameter int IMG_W       = DEF_W,
  parameter int IMG_H       = DEF_H,
  parameter int DATA_WIDTH  = DEF_DW,
  parameter int ADDR_WIDTH  = DEF_AW,
  parameter int FILTER_SIZE = DEF_K,
  parameter logic [ADDR_WIDTH-1:0] COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE = 'h0000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  output logic     done,
  col2im_if.master mem
);
  localparam int M         = IMG_H * IMG_W * IMG_C;
  localparam int ACC_WIDTH = acc_w(DATA_WIDTH, FILTER_SIZE);
  localparam int IW        = cw(M);
  localparam int RW        = cw(IMG_H);
  localparam int CXW       = cw(IMG_W);
  localparam int CHW       = cw(IMG_C);

  state_t state, state_nx;

  logic                  take, step, inb, last, last_wr;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [RW-1:0]         ty;
  logic [CXW-1:0]        tx;
  logic [CHW-1:0]        tch;
  logic [IW-1:0]         pix, tap_pix, wcnt;
  logic                  tap_v, tap_inb;
  logic [ACC_WIDTH-1:0]  acc [M];
  logic [ACC_WIDTH-1:0]  rd_acc;
  logic [DATA_WIDTH-1:0] sat_v, data_wr_q;
  logic [ADDR_WIDTH-1:0] addr_wr_q;
  logic                  wr_en_q, done_q;

  assign take    = start && (state == IDLE || state == DONE);
  assign step    = (state == READ) && !last;
  assign last_wr = (wcnt == IW'(M - 1));

  col2im_addr_gen #(
    .IMG_C       (IMG_C),
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .FILTER_SIZE (FILTER_SIZE),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COL_BASE    (COL_BASE)
  ) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (take),
    .step  (step),
    .addr  (addr_rd),
    .ty    (ty),
    .tx    (tx),
    .tch   (tch),
    .inb   (inb),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (last) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   if (last_wr) state_nx = DONE;
      DONE:    if (start) state_nx = READ;
      default: state_nx = IDLE;
    endcase
  end

  assign pix = IW'((int'(ty) * IMG_W + int'(tx)) * IMG_C + int'(tch));

  // tap target travels one cycle to meet its read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_v   <= 1'b0;
      tap_inb <= 1'b0;
      tap_pix <= '0;
    end else begin
      tap_v   <= (state == READ);
      tap_inb <= inb;
      tap_pix <= pix;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      for (int i = 0; i < M; i++) acc[i] <= '0;
    end else if (tap_v && tap_inb) begin
      acc[tap_pix] <= acc[tap_pix] + ACC_WIDTH'(mem.data_rd);
    end
  end

  assign rd_acc = acc[wcnt];
  assign sat_v  = (rd_acc > ACC_WIDTH'({DATA_WIDTH{1'b1}})) ?
                  '1 : rd_acc[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      addr_wr_q <= IMG_BASE;
      data_wr_q <= '0;
      done_q    <= 1'b0;
      wcnt      <= '0;
    end else begin
      wr_en_q <= (state == WRITE);
      done_q  <= (state == DONE) && !start;
      if (state == WRITE) begin
        addr_wr_q <= IMG_BASE + ADDR_WIDTH'(wcnt);
        data_wr_q <= sat_v;
        wcnt      <= last_wr ? '0 : wcnt + 1'b1;
      end
    end
  end

  assign mem.addr_rd   = addr_rd;
  assign mem.addr_wr   = addr_wr_q;
  assign mem.data_wr   = data_wr_q;
  assign mem.mem_wr_en = wr_en_q;
  assign done          = done_q;

endmodule

// File: tb/tb_col2im.sv
// tb_col2im: self-checking bench for col2im in three geometries.
// Column memory model, write capture, and a tap-summing reference.
module tb_col2im;
  localparam logic [31:0] CB = 32'h2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic done_a, done_b, done_c;

  always #5 clk = ~clk;

  col2im_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) ifa ();
  col2im_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) ifb ();
  col2im_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) ifc ();

  col2im #(.IMG_C(1), .IMG_W(4), .IMG_H(4), .DATA_WIDTH(8),
    .ADDR_WIDTH(32), .FILTER_SIZE(3), .COL_BASE(32'h2000),
    .IMG_BASE(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a), .mem(ifa));

  col2im #(.IMG_C(2), .IMG_W(3), .IMG_H(3), .DATA_WIDTH(8),
    .ADDR_WIDTH(32), .FILTER_SIZE(1), .COL_BASE(32'h2000),
    .IMG_BASE(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b), .mem(ifb));

  col2im #(.IMG_C(1), .IMG_W(8), .IMG_H(8), .DATA_WIDTH(8),
    .ADDR_WIDTH(32), .FILTER_SIZE(3), .COL_BASE(32'h2000),
    .IMG_BASE(32'h0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .done(done_c), .mem(ifc));

  logic [7:0] col_mem [0:1023];
  logic [7:0] img_cap [0:255];
  int exp_img [0:255];
  int tests = 0, fails = 0;
  int sel = 0, run_id = 0, seen_id = 0, wr_cnt = 0, wr_bad = 0;

  typedef struct {
    logic [7:0] val;
    int corner;
    int edg;
    int inner;
  } vec_t;
  vec_t vt [5];

  function automatic logic [7:0] rdm(input logic [31:0] a);
    logic [31:0] o;
    o = a - CB;
    return (o < 32'd1024) ? col_mem[o[9:0]] : 8'h00;
  endfunction

  always @(posedge clk) ifa.data_rd <= rdm(ifa.addr_rd);
  always @(posedge clk) ifb.data_rd <= rdm(ifb.addr_rd);
  always @(posedge clk) ifc.data_rd <= rdm(ifc.addr_rd);

  always @(negedge clk) begin : cap
    logic we;
    logic [31:0] a;
    logic [7:0] d;
    if (run_id != seen_id) begin
      wr_cnt = 0;
      wr_bad = 0;
      seen_id = run_id;
    end
    case (sel)
      0: begin we = ifa.mem_wr_en; a = ifa.addr_wr; d = ifa.data_wr; end
      1: begin we = ifb.mem_wr_en; a = ifb.addr_wr; d = ifb.data_wr; end
      default: begin we = ifc.mem_wr_en; a = ifc.addr_wr; d = ifc.data_wr; end
    endcase
    if (we) begin
      if (wr_cnt > 255 || a != 32'(wr_cnt)) wr_bad++;
      else img_cap[wr_cnt] = d;
      wr_cnt++;
    end
  end

  task automatic check(input string nm, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic check_img(input string nm, input int m);
    int bad = 0;
    int fi = 0;
    for (int i = 0; i < m; i++)
      if (img_cap[i] !== 8'(exp_img[i])) begin
        if (bad == 0) fi = i;
        bad++;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d pixels differ, first [%0d] got %0d want %0d",
               nm, bad, fi, img_cap[fi], exp_img[fi]);
    end
  endtask

  // each column tap adds into its source pixel; padding taps vanish
  task automatic model(input int w, input int h, input int c, input int k);
    int s [256];
    int p;
    p = (k - 1) / 2;
    foreach (s[i]) s[i] = 0;
    for (int r = 0; r < h; r++)
      for (int cc = 0; cc < w; cc++)
        for (int ch = 0; ch < c; ch++)
          for (int fr = 0; fr < k; fr++)
            for (int fc = 0; fc < k; fc++) begin
              int y, x, idx;
              y = r + fr - p;
              x = cc + fc - p;
              idx = ((r * w + cc) * c + ch) * k * k + fr * k + fc;
              if (y >= 0 && y < h && x >= 0 && x < w)
                s[(y * w + x) * c + ch] += int'(col_mem[idx]);
            end
    for (int i = 0; i < w * h * c; i++)
      exp_img[i] = (s[i] > 255) ? 255 : s[i];
  endtask

  task automatic fill(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) col_mem[i] = v;
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // start edge is edge 0; cyc = edges until done seen high
  task automatic run(input int w, input int pulse_at,
                     output int cyc, output logic d1);
    run_id++;
    sel = w;
    cyc = -1;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    d1 = get_done(w);
    set_start(w, 1'b0);
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin
        cyc = k;
        break;
      end
      set_start(w, k == pulse_at);
    end
    set_start(w, 1'b0);
  endtask

  task automatic check_a(input string nm, input int v);
    check({nm, " corner0"}, img_cap[0], vt[v].corner);
    check({nm, " corner3"}, img_cap[3], vt[v].corner);
    check({nm, " edge"}, img_cap[1], vt[v].edg);
    check({nm, " inner"}, img_cap[5], vt[v].inner);
  endtask

  initial begin
    int cyc;
    logic d1;
    int pv [64];

    vt[0] = '{8'h01, 4, 6, 9};
    vt[1] = '{8'h20, 8'h80, 8'hC0, 8'hFF};
    vt[2] = '{8'h10, 8'h40, 8'h60, 8'h90};
    vt[3] = '{8'h00, 0, 0, 0};
    vt[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (col_mem[i]) col_mem[i] = 8'h00;
    foreach (img_cap[i]) img_cap[i] = 8'h00;

    repeat (3) @(posedge clk); #1;
    check("rst done", done_a, 0);
    check("rst wr_en", ifa.mem_wr_en, 0);
    check("rst addr_rd", ifa.addr_rd, CB);
    check("rst addr_wr", ifa.addr_wr, 0);
    check("rst data_wr", ifa.data_wr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      fill(144, vt[v].val);
      model(4, 4, 1, 3);
      run(0, 0, cyc, d1);
      check($sformatf("const%0d cycles", v), cyc, 162);
      check($sformatf("const%0d writes", v), wr_cnt, 16);
      check($sformatf("const%0d wr order", v), wr_bad, 0);
      check($sformatf("const%0d done drop", v), d1, 0);
      check_a($sformatf("const%0d", v), v);
      check_img($sformatf("const%0d image", v), 16);
    end

    fill(144, 8'h01);
    run(0, 150, cyc, d1);
    check("start in WRITE cycles", cyc, 162);
    check("start in WRITE writes", wr_cnt, 16);
    check_a("start in WRITE", 0);
    repeat (2) @(posedge clk); #1;
    check("done held", done_a, 1);
    run(0, 0, cyc, d1);
    check("restart from DONE drop", d1, 0);
    check("restart from DONE cycles", cyc, 162);
    check_a("restart from DONE", 0);

    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    repeat (40) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset done", done_a, 0);
    check("midreset wr_en", ifa.mem_wr_en, 0);
    check("midreset addr_rd", ifa.addr_rd, CB);
    check("midreset data_wr", ifa.data_wr, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("idle addr_rd", ifa.addr_rd, CB);
    check("idle done", done_a, 0);
    run(0, 0, cyc, d1);
    check("after reset cycles", cyc, 162);
    check("after reset writes", wr_cnt, 16);
    check_a("after reset", 0);

    for (int i = 0; i < 18; i++) begin
      col_mem[i] = 8'(i);
      exp_img[i] = i;
    end
    run(1, 0, cyc, d1);
    check("K1 ramp cycles", cyc, 38);
    check("K1 ramp writes", wr_cnt, 18);
    check("K1 ramp order", wr_bad, 0);
    check_img("K1 ramp image", 18);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 144; i++)
        col_mem[i] = 8'($urandom_range(0, (n == 0) ? 28 : 255));
      model(4, 4, 1, 3);
      run(0, 0, cyc, d1);
      check($sformatf("rand A%0d cycles", n), cyc, 162);
      check_img($sformatf("rand A%0d image", n), 16);
      for (int i = 0; i < 18; i++)
        col_mem[i] = 8'($urandom_range(0, 255));
      model(3, 3, 2, 1);
      run(1, 0, cyc, d1);
      check($sformatf("rand B%0d cycles", n), cyc, 38);
      check_img($sformatf("rand B%0d image", n), 18);
    end

    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 64; i++)
        pv[i] = $urandom_range(0, (n == 0) ? 28 : 255);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          for (int fr = 0; fr < 3; fr++)
            for (int fc = 0; fc < 3; fc++) begin
              int y, x;
              y = r + fr - 1;
              x = c + fc - 1;
              col_mem[(r * 8 + c) * 9 + fr * 3 + fc] =
                (y >= 0 && y < 8 && x >= 0 && x < 8) ? 8'(pv[y * 8 + x]) : 8'h00;
            end
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          int cy, cx, e;
          cy = 1 + ((y > 0) ? 1 : 0) + ((y < 7) ? 1 : 0);
          cx = 1 + ((x > 0) ? 1 : 0) + ((x < 7) ? 1 : 0);
          e = pv[y * 8 + x] * cy * cx;
          exp_img[y * 8 + x] = (e > 255) ? 255 : e;
        end
      run(2, 0, cyc, d1);
      check($sformatf("roundtrip%0d cycles", n), cyc, 642);
      check($sformatf("roundtrip%0d writes", n), wr_cnt, 64);
      check_img($sformatf("roundtrip%0d image", n), 64);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
